seq_alu: RTL and testbench

//  Parametrised sequential successor to the combinational 4-bit bitwise/arith ops.

---
 rtl/seq_alu.sv | 157 +++++++++++++++
 tb/tb_seq_alu.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on the operation and result sides.
// Bitwise, ADD/SUB/CMP finish in one cycle; MUL runs one shift-add step per cycle.
module seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 zero,
    output logic                 carry,
    output logic                 ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  accept;
    logic [2*WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]      mplier;
    logic [CW-1:0]         cnt;
    logic [2*WIDTH-1:0]    mul_next;
    logic [2*WIDTH-1:0]    op_res;
    logic                  op_carry;
    logic                  op_ovf;
    logic [WIDTH:0]        sum;
    logic [WIDTH-1:0]      diff;

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == HOLD);
    assign sum       = {1'b0, a} + {1'b0, b};
    assign diff      = a - b;
    assign mul_next  = result + (mplier[0] ? mcand : {(2*WIDTH){1'b0}});

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the transfer cycle always returns to IDLE, so no overlap
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (op == OP_MUL) ? EXEC : HOLD;
                end else begin
                    state_next = IDLE;
                end
            end
            EXEC: begin
                if (cnt == LAST_STEP) begin
                    state_next = HOLD;
                end else begin
                    state_next = EXEC;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end else begin
                    state_next = HOLD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle operation results, evaluated straight from the inputs on accept
    always_comb begin
        op_res   = {(2*WIDTH){1'b0}};
        op_carry = 1'b0;
        op_ovf   = 1'b0;
        case (op)
            OP_AND: op_res[WIDTH-1:0] = a & b;
            OP_OR:  op_res[WIDTH-1:0] = a | b;
            OP_XOR: op_res[WIDTH-1:0] = a ^ b;
            OP_NOT: op_res[WIDTH-1:0] = ~a;
            OP_ADD: begin
                op_res[WIDTH-1:0] = sum[WIDTH-1:0];
                op_carry = sum[WIDTH];
                op_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                op_res[WIDTH-1:0] = diff;
                op_carry = (a < b);
                op_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_CMP: op_res[2:0] = {(a > b), (a == b), (a < b)};
            default: op_res = {(2*WIDTH){1'b0}};
        endcase
    end

    // Result/flag registers; result doubles as the multiply accumulator during EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= {(2*WIDTH){1'b0}};
            zero   <= 1'b0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            mcand  <= {(2*WIDTH){1'b0}};
            mplier <= {WIDTH{1'b0}};
            cnt    <= {CW{1'b0}};
        end else if (accept) begin
            if (op == OP_MUL) begin
                result <= {(2*WIDTH){1'b0}};
                zero   <= 1'b0;
                carry  <= 1'b0;
                ovf    <= 1'b0;
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                cnt    <= {CW{1'b0}};
            end else begin
                result <= op_res;
                zero   <= (op_res == {(2*WIDTH){1'b0}});
                carry  <= op_carry;
                ovf    <= op_ovf;
            end
        end else if (state == EXEC) begin
            result <= mul_next;
            zero   <= (mul_next == {(2*WIDTH){1'b0}});
            mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            cnt    <= cnt + CW'(1);
        end else begin
            result <= result;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=4).
module tb_seq_alu;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_alu #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation for exactly one rising edge (caller ensures IDLE).
    task automatic send(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
        #1;
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Check a single-cycle op: result/flags visible right after the accept edge.
    task automatic check_single(input string name, input logic [2:0] o,
                                input logic [3:0] x, input logic [3:0] y,
                                input logic [7:0] er, input logic ez,
                                input logic ec, input logic eo);
        out_ready = 1'b1;
        send(o, x, y);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL %s_valid: got %b want 1", name, out_valid);
        end
        n_cmp++;
        if ({result, zero, carry, ovf} !== {er, ez, ec, eo}) begin
            n_fail++;
            $display("FAIL %s_result: got res=%b z=%b c=%b v=%b want res=%b z=%b c=%b v=%b",
                     name, result, zero, carry, ovf, er, ez, ec, eo);
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL %s_release: got ov/ir=%b%b want 01", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 3'b000; a = 4'h0; b = 4'h0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, result, zero, carry, ovf} !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_state: got ir=%b ov=%b res=%b z=%b c=%b v=%b want all 0",
                     in_ready, out_valid, result, zero, carry, ovf);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
        // Abort a multiply part-way through
        send(3'b111, 4'hF, 4'hF);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, result} !== {1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_mid_mul: got ir=%b ov=%b res=%b want ir=1 ov=0 res=00000000",
                     in_ready, out_valid, result);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_no_valid_after_abort[%0d]: got %b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_logic();
        check_single("and",  3'b000, 4'b1010, 4'b1001, 8'b0000_1000, 1'b0, 1'b0, 1'b0);
        check_single("and0", 3'b000, 4'b1010, 4'b0101, 8'b0000_0000, 1'b1, 1'b0, 1'b0);
        check_single("or",   3'b001, 4'b1100, 4'b0011, 8'b0000_1111, 1'b0, 1'b0, 1'b0);
        check_single("xor",  3'b010, 4'b1100, 4'b1010, 8'b0000_0110, 1'b0, 1'b0, 1'b0);
        check_single("not",  3'b011, 4'b0000, 4'b1111, 8'b0000_1111, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_arith();
        check_single("add_wrap", 3'b100, 4'b1111, 4'b0001, 8'b0000_0000, 1'b1, 1'b1, 1'b0);
        check_single("add_ovf",  3'b100, 4'b0111, 4'b0001, 8'b0000_1000, 1'b0, 1'b0, 1'b1);
        check_single("sub_brw",  3'b101, 4'b0011, 4'b0101, 8'b0000_1110, 1'b0, 1'b1, 1'b0);
        check_single("sub_ovf",  3'b101, 4'b1000, 4'b0001, 8'b0000_0111, 1'b0, 1'b0, 1'b1);
        check_single("cmp_gt",   3'b110, 4'b0101, 4'b0011, 8'b0000_0100, 1'b0, 1'b0, 1'b0);
        check_single("cmp_eq",   3'b110, 4'b1001, 4'b1001, 8'b0000_0010, 1'b0, 1'b0, 1'b0);
        check_single("cmp_lt",   3'b110, 4'b0001, 4'b1110, 8'b0000_0001, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mul(input string name, input logic [3:0] x, input logic [3:0] y,
                            input logic [7:0] er, input logic ez);
        out_ready = 1'b1;
        send(3'b111, x, y);
        // Inputs moving during EXEC must not disturb the product
        op = 3'b000; a = ~x; b = ~y;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL %s_early_valid[%0d]: got %b want 0", name, k, out_valid);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL %s_latency: got out_valid=%b want 1 at cycle 4", name, out_valid);
        end
        n_cmp++;
        if ({result, zero, carry, ovf} !== {er, ez, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_result: got res=%b z=%b c=%b v=%b want res=%b z=%b c=0 v=0",
                     name, result, zero, carry, ovf, er, ez);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(3'b010, 4'b1100, 4'b1010);
        op = 3'b001; a = 4'hF; b = 4'hF; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 8'b0000_0110}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got ov=%b ir=%b res=%b want ov=1 ir=0 res=00000110",
                         k, out_valid, in_ready, result);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL bp_release: got ov/ir=%b%b want 01", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int accepts;
        accepts = 0;
        out_ready = 1'b1;
        op = 3'b001; a = 4'b1100; b = 4'b0011;
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready === out_valid) begin
                n_fail++; $display("FAIL b2b_phase[%0d]: got ir=%b ov=%b want opposite", k, in_ready, out_valid);
            end
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (result !== 8'b0000_1111) begin
                    n_fail++; $display("FAIL b2b_result[%0d]: got %b want 00001111", k, result);
                end
            end
            if (in_valid && in_ready) accepts++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (accepts != 4) begin
            n_fail++; $display("FAIL b2b_accepts: got %0d want 4", accepts);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_logic();
        test_arith();
        test_mul("mul_ff", 4'hF, 4'hF, 8'b1110_0001, 1'b0);
        test_mul("mul_0",  4'h7, 4'h0, 8'b0000_0000, 1'b1);
        test_mul("mul_53", 4'h5, 4'h3, 8'b0000_1111, 1'b0);
        test_backpressure();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
